// File: rtl/axi_lite_rr_mux.sv
// axi_lite_rr_mux: shares one AXI4-Lite master port among NumSlv requesters with round-robin arbitration.
module axi_lite_rr_mux_fifo #(
    parameter int Depth = 4,
    parameter int Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [Width-1:0] din,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int PW = Depth > 1 ? $clog2(Depth) : 1;
    localparam int CW = $clog2(Depth + 1);
    logic [Width-1:0] mem [Depth];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (32'(p) == Depth - 1) ? '0 : p + 1'b1;
    endfunction

    assign full    = count == CW'(Depth);
    assign empty   = count == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i)
        if (do_push) mem[wr_ptr] <= din;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

module axi_lite_rr_mux_arb #(
    parameter int N    = 4,
    parameter int IdxW = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req,
    input  logic            gate,
    input  logic            ready,
    output logic [IdxW-1:0] grant,
    output logic            valid,
    output logic            hs
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_next;
    logic [IdxW-1:0] ptr, sel, win;
    logic found;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE) sel <= win;
            if (hs) ptr <= (32'(grant) == N - 1) ? '0 : grant + 1'b1;
        end
    end

    // first requester at or after ptr, wrapping
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[(int'(ptr) + k) % N]) begin
                found = 1'b1;
                win   = IdxW'((int'(ptr) + k) % N);
            end
        end
    end

    always_comb
        state_next = (state == IDLE) ? ((valid && !ready) ? LOCKED : IDLE) : (hs ? IDLE : LOCKED);

    always_comb begin
        grant = (state == LOCKED) ? sel : win;
        valid = ~rst_i & gate & ((state == LOCKED) ? req[sel] : found);
        hs    = valid & ready;
    end
endmodule

module axi_lite_rr_mux #(
    parameter int NumSlv    = 4,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int MaxTxns   = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumSlv*AddrWidth-1:0]     slv_aw_addr_i,
    input  logic [NumSlv*3-1:0]             slv_aw_prot_i,
    input  logic [NumSlv-1:0]               slv_aw_valid_i,
    output logic [NumSlv-1:0]               slv_aw_ready_o,
    input  logic [NumSlv*DataWidth-1:0]     slv_w_data_i,
    input  logic [NumSlv*DataWidth/8-1:0]   slv_w_strb_i,
    input  logic [NumSlv-1:0]               slv_w_valid_i,
    output logic [NumSlv-1:0]               slv_w_ready_o,
    output logic [NumSlv*2-1:0]             slv_b_resp_o,
    output logic [NumSlv-1:0]               slv_b_valid_o,
    input  logic [NumSlv-1:0]               slv_b_ready_i,
    input  logic [NumSlv*AddrWidth-1:0]     slv_ar_addr_i,
    input  logic [NumSlv*3-1:0]             slv_ar_prot_i,
    input  logic [NumSlv-1:0]               slv_ar_valid_i,
    output logic [NumSlv-1:0]               slv_ar_ready_o,
    output logic [NumSlv*DataWidth-1:0]     slv_r_data_o,
    output logic [NumSlv*2-1:0]             slv_r_resp_o,
    output logic [NumSlv-1:0]               slv_r_valid_o,
    input  logic [NumSlv-1:0]               slv_r_ready_i,
    output logic [AddrWidth-1:0]            mst_aw_addr_o,
    output logic [2:0]                      mst_aw_prot_o,
    output logic                            mst_aw_valid_o,
    input  logic                            mst_aw_ready_i,
    output logic [DataWidth-1:0]            mst_w_data_o,
    output logic [DataWidth/8-1:0]          mst_w_strb_o,
    output logic                            mst_w_valid_o,
    input  logic                            mst_w_ready_i,
    input  logic [1:0]                      mst_b_resp_i,
    input  logic                            mst_b_valid_i,
    output logic                            mst_b_ready_o,
    output logic [AddrWidth-1:0]            mst_ar_addr_o,
    output logic [2:0]                      mst_ar_prot_o,
    output logic                            mst_ar_valid_o,
    input  logic                            mst_ar_ready_i,
    input  logic [DataWidth-1:0]            mst_r_data_i,
    input  logic [1:0]                      mst_r_resp_i,
    input  logic                            mst_r_valid_i,
    output logic                            mst_r_ready_o
);
    localparam int IdxW  = NumSlv > 1 ? $clog2(NumSlv) : 1;
    localparam int StrbW = DataWidth / 8;
    logic [IdxW-1:0] aw_grant, ar_grant, w_head, b_head, r_head;
    logic aw_hs, ar_hs, w_empty, w_full, b_empty, b_full, r_empty, r_full;

    axi_lite_rr_mux_arb #(.N(NumSlv), .IdxW(IdxW)) u_aw_arb (
        .clk_i(clk_i), .rst_i(rst_i), .req(slv_aw_valid_i), .gate(~w_full & ~b_full),
        .ready(mst_aw_ready_i), .grant(aw_grant), .valid(mst_aw_valid_o), .hs(aw_hs)
    );

    axi_lite_rr_mux_arb #(.N(NumSlv), .IdxW(IdxW)) u_ar_arb (
        .clk_i(clk_i), .rst_i(rst_i), .req(slv_ar_valid_i), .gate(~r_full),
        .ready(mst_ar_ready_i), .grant(ar_grant), .valid(mst_ar_valid_o), .hs(ar_hs)
    );

    // each accepted address records its owner for the data and response legs
    axi_lite_rr_mux_fifo #(.Depth(MaxTxns), .Width(IdxW)) u_w_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push(aw_hs), .din(aw_grant),
        .pop(mst_w_valid_o & mst_w_ready_i), .head(w_head), .empty(w_empty), .full(w_full)
    );

    axi_lite_rr_mux_fifo #(.Depth(MaxTxns), .Width(IdxW)) u_b_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push(aw_hs), .din(aw_grant),
        .pop(mst_b_valid_i & mst_b_ready_o), .head(b_head), .empty(b_empty), .full(b_full)
    );

    axi_lite_rr_mux_fifo #(.Depth(MaxTxns), .Width(IdxW)) u_r_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .push(ar_hs), .din(ar_grant),
        .pop(mst_r_valid_i & mst_r_ready_o), .head(r_head), .empty(r_empty), .full(r_full)
    );

    always_comb begin
        mst_aw_addr_o            = slv_aw_addr_i[aw_grant*AddrWidth +: AddrWidth];
        mst_aw_prot_o            = slv_aw_prot_i[aw_grant*3 +: 3];
        slv_aw_ready_o           = '0;
        slv_aw_ready_o[aw_grant] = aw_hs;
        mst_ar_addr_o            = slv_ar_addr_i[ar_grant*AddrWidth +: AddrWidth];
        mst_ar_prot_o            = slv_ar_prot_i[ar_grant*3 +: 3];
        slv_ar_ready_o           = '0;
        slv_ar_ready_o[ar_grant] = ar_hs;
        mst_w_data_o             = slv_w_data_i[w_head*DataWidth +: DataWidth];
        mst_w_strb_o             = slv_w_strb_i[w_head*StrbW +: StrbW];
        mst_w_valid_o            = ~w_empty & slv_w_valid_i[w_head];
        slv_w_ready_o            = '0;
        slv_w_ready_o[w_head]    = ~w_empty & mst_w_ready_i;
        slv_b_resp_o             = {NumSlv{mst_b_resp_i}};
        slv_b_valid_o            = '0;
        slv_b_valid_o[b_head]    = ~b_empty & mst_b_valid_i;
        mst_b_ready_o            = ~b_empty & slv_b_ready_i[b_head];
        slv_r_data_o             = {NumSlv{mst_r_data_i}};
        slv_r_resp_o             = {NumSlv{mst_r_resp_i}};
        slv_r_valid_o            = '0;
        slv_r_valid_o[r_head]    = ~r_empty & mst_r_valid_i;
        mst_r_ready_o            = ~r_empty & slv_r_ready_i[r_head];
    end
endmodule

// File: tb/tb_axi_lite_rr_mux.sv
// tb_axi_lite_rr_mux: directed scoreboard bench for the round-robin AXI4-Lite mux.
module tb_axi_lite_rr_mux;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst_i;
    logic [N*32-1:0] slv_aw_addr_i, slv_ar_addr_i, slv_w_data_i, slv_r_data_o;
    logic [N*3-1:0]  slv_aw_prot_i, slv_ar_prot_i;
    logic [N*4-1:0]  slv_w_strb_i;
    logic [N*2-1:0]  slv_b_resp_o, slv_r_resp_o;
    logic [N-1:0]    slv_aw_valid_i, slv_aw_ready_o, slv_w_valid_i, slv_w_ready_o;
    logic [N-1:0]    slv_b_valid_o, slv_b_ready_i, slv_ar_valid_i, slv_ar_ready_o;
    logic [N-1:0]    slv_r_valid_o, slv_r_ready_i;
    logic [31:0]     mst_aw_addr_o, mst_ar_addr_o, mst_w_data_o, mst_r_data_i;
    logic [2:0]      mst_aw_prot_o, mst_ar_prot_o;
    logic [3:0]      mst_w_strb_o;
    logic [1:0]      mst_b_resp_i, mst_r_resp_i;
    logic mst_aw_valid_o, mst_aw_ready_i, mst_w_valid_o, mst_w_ready_i;
    logic mst_b_valid_i, mst_b_ready_o, mst_ar_valid_o, mst_ar_ready_i;
    logic mst_r_valid_i, mst_r_ready_o;
    int tests = 0, fails = 0, cyc = 0;
    logic [31:0] exp_aw[$], exp_w[$], exp_ar[$];
    logic [3:0]  exp_b[$];
    logic [35:0] exp_r[$];

    axi_lite_rr_mux #(.NumSlv(N), .AddrWidth(32), .DataWidth(32), .MaxTxns(2)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .slv_aw_addr_i(slv_aw_addr_i), .slv_aw_prot_i(slv_aw_prot_i), .slv_aw_valid_i(slv_aw_valid_i),
        .slv_aw_ready_o(slv_aw_ready_o), .slv_w_data_i(slv_w_data_i), .slv_w_strb_i(slv_w_strb_i),
        .slv_w_valid_i(slv_w_valid_i), .slv_w_ready_o(slv_w_ready_o), .slv_b_resp_o(slv_b_resp_o),
        .slv_b_valid_o(slv_b_valid_o), .slv_b_ready_i(slv_b_ready_i), .slv_ar_addr_i(slv_ar_addr_i),
        .slv_ar_prot_i(slv_ar_prot_i), .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o),
        .slv_r_data_o(slv_r_data_o), .slv_r_resp_o(slv_r_resp_o), .slv_r_valid_o(slv_r_valid_o),
        .slv_r_ready_i(slv_r_ready_i), .mst_aw_addr_o(mst_aw_addr_o), .mst_aw_prot_o(mst_aw_prot_o),
        .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i), .mst_w_data_o(mst_w_data_o),
        .mst_w_strb_o(mst_w_strb_o), .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(mst_w_ready_i),
        .mst_b_resp_i(mst_b_resp_i), .mst_b_valid_i(mst_b_valid_i), .mst_b_ready_o(mst_b_ready_o),
        .mst_ar_addr_o(mst_ar_addr_o), .mst_ar_prot_o(mst_ar_prot_o), .mst_ar_valid_o(mst_ar_valid_o),
        .mst_ar_ready_i(mst_ar_ready_i), .mst_r_data_i(mst_r_data_i), .mst_r_resp_i(mst_r_resp_i),
        .mst_r_valid_i(mst_r_valid_i), .mst_r_ready_o(mst_r_ready_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] aw_a(input int i, input int k);
        return 32'hA000_0000 | 32'(i << 8) | 32'(k);
    endfunction

    function automatic logic [31:0] w_d(input int i, input int k);
        return 32'hD000_0000 | 32'(i << 8) | 32'(k);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name, input int i);
        tests++;
        fails++;
        $display("FAIL %s: requester %0d got an unmatched event, expected none", name, i);
    endtask

    task automatic expect_write(input int i, input int k);
        exp_aw.push_back(aw_a(i, k));
        exp_w.push_back(w_d(i, k));
        exp_b.push_back({2'(i), 2'b10});
    endtask

    task automatic do_write(input int i, input int k);
        int n;
        slv_aw_addr_i[i*32 +: 32] = aw_a(i, k);
        slv_aw_prot_i[i*3 +: 3]   = 3'(i);
        slv_aw_valid_i[i]         = 1'b1;
        slv_w_data_i[i*32 +: 32]  = w_d(i, k);
        slv_w_strb_i[i*4 +: 4]    = 4'hF;
        slv_w_valid_i[i]          = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (slv_aw_ready_o[i]) break;
        end
        if (n == 100) fail_event("aw_timeout", i);
        else begin @(posedge clk); #1; end
        slv_aw_valid_i[i] = 1'b0;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (slv_w_ready_o[i]) break;
        end
        if (n == 100) fail_event("w_timeout", i);
        else begin @(posedge clk); #1; end
        slv_w_valid_i[i] = 1'b0;
    endtask

    task automatic do_read(input int i, input logic [31:0] a);
        int n;
        slv_ar_addr_i[i*32 +: 32] = a;
        slv_ar_prot_i[i*3 +: 3]   = 3'(i);
        slv_ar_valid_i[i]         = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (slv_ar_ready_o[i]) break;
        end
        if (n == 100) fail_event("ar_timeout", i);
        else begin @(posedge clk); #1; end
        slv_ar_valid_i[i] = 1'b0;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (slv_r_valid_o[i]) break;
        end
        if (n == 100) fail_event("r_timeout", i);
    endtask

    // scoreboard: every master/requester handshake must match the head of its queue
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (mst_aw_valid_o && mst_aw_ready_i) begin
                    if (exp_aw.size() == 0) fail_event("aw_extra", 0);
                    else check("aw_addr", mst_aw_addr_o, exp_aw.pop_front());
                end
                if (mst_w_valid_o && mst_w_ready_i) begin
                    if (exp_w.size() == 0) fail_event("w_extra", 0);
                    else check("w_data", mst_w_data_o, exp_w.pop_front());
                end
                if (mst_ar_valid_o && mst_ar_ready_i) begin
                    if (exp_ar.size() == 0) fail_event("ar_extra", 0);
                    else check("ar_addr", mst_ar_addr_o, exp_ar.pop_front());
                end
                for (int i = 0; i < N; i++) begin
                    if (slv_b_valid_o[i] && slv_b_ready_i[i]) begin
                        if (exp_b.size() == 0) fail_event("b_extra", i);
                        else check("b_route", {2'(i), slv_b_resp_o[i*2 +: 2]}, exp_b.pop_front());
                    end
                    if (slv_r_valid_o[i] && slv_r_ready_i[i]) begin
                        if (exp_r.size() == 0) fail_event("r_extra", i);
                        else check("r_route", {2'(i), slv_r_resp_o[i*2 +: 2], slv_r_data_o[i*32 +: 32]}, exp_r.pop_front());
                    end
                end
            end
        end
    endtask

    initial begin
        int start;
        rst_i          = 1'b1;
        slv_aw_valid_i = '1;
        slv_w_valid_i  = '1;
        slv_ar_valid_i = '1;
        slv_w_data_i   = '0;
        slv_w_strb_i   = '1;
        slv_ar_addr_i  = '0;
        slv_ar_prot_i  = '0;
        for (int i = 0; i < N; i++) begin
            slv_aw_addr_i[i*32 +: 32] = aw_a(i, 0);
            slv_aw_prot_i[i*3 +: 3]   = 3'(i);
        end
        slv_b_ready_i  = '1;
        slv_r_ready_i  = '1;
        mst_aw_ready_i = 1'b0;
        mst_w_ready_i  = 1'b1;
        mst_ar_ready_i = 1'b0;
        mst_b_valid_i  = 1'b1;
        mst_b_resp_i   = 2'b10;
        mst_r_valid_i  = 1'b1;
        mst_r_data_i   = 32'h1234_5678;
        mst_r_resp_i   = 2'b00;
        fork monitor(); join_none
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mst_valid", {mst_aw_valid_o, mst_w_valid_o, mst_ar_valid_o}, 0);
        check("rst_mst_ready", {mst_b_ready_o, mst_r_ready_o}, 0);
        check("rst_slv_ready", {slv_aw_ready_o, slv_w_ready_o, slv_ar_ready_o}, 0);
        check("rst_slv_valid", {slv_b_valid_o, slv_r_valid_o}, 0);
        @(posedge clk); #1;
        rst_i          = 1'b0;
        slv_w_valid_i  = '0;
        slv_ar_valid_i = '0;
        @(negedge clk);
        check("first_grant_valid", mst_aw_valid_o, 1);
        check("first_grant_addr", mst_aw_addr_o, aw_a(0, 0));
        // round robin: all four contend, then requester 0 again
        for (int i = 0; i < N; i++) expect_write(i, 0);
        expect_write(0, 1);
        @(posedge clk); #1;
        mst_aw_ready_i = 1'b1;
        fork
            do_write(0, 0);
            do_write(1, 0);
            do_write(2, 0);
            do_write(3, 0);
        join
        do_write(0, 1);
        repeat (2) @(posedge clk);
        #1;
        // lock: requester 2 stalled while requester 1 joins
        mst_aw_ready_i = 1'b0;
        expect_write(2, 2);
        expect_write(1, 2);
        fork
            do_write(2, 2);
            begin @(posedge clk); #1; do_write(1, 2); end
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("lock_addr", mst_aw_addr_o, aw_a(2, 2));
                end
                @(posedge clk); #1;
                mst_aw_ready_i = 1'b1;
            end
        join
        repeat (2) @(posedge clk);
        #1;
        // full: two writes outstanding with B withheld
        mst_b_valid_i = 1'b0;
        expect_write(2, 3);
        expect_write(0, 3);
        expect_write(1, 3);
        do_write(2, 3);
        do_write(0, 3);
        fork
            do_write(1, 3);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("full_stall", {mst_aw_valid_o, slv_aw_ready_o}, 0);
                end
                @(posedge clk); #1;
                mst_b_valid_i = 1'b1;
                @(negedge clk);
                check("full_pop_cycle", mst_aw_valid_o, 0);
                @(posedge clk); #1;
                mst_b_valid_i = 1'b0;
                @(negedge clk);
                check("full_release", {mst_aw_valid_o, mst_aw_addr_o}, {1'b1, aw_a(1, 3)});
            end
        join
        mst_b_valid_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        // W raised four cycles ahead of its AW
        expect_write(3, 4);
        slv_w_data_i[3*32 +: 32]  = w_d(3, 4);
        slv_w_valid_i[3]          = 1'b1;
        slv_aw_addr_i[3*32 +: 32] = aw_a(3, 4);
        repeat (4) begin
            @(negedge clk);
            check("w_early_stall", {slv_w_ready_o[3], mst_w_valid_o}, 0);
        end
        @(posedge clk); #1;
        slv_aw_valid_i[3] = 1'b1;
        @(negedge clk);
        check("w_at_aw_hs", {slv_aw_ready_o[3], slv_w_ready_o[3]}, 2'b10);
        @(posedge clk); #1;
        slv_aw_valid_i[3] = 1'b0;
        @(negedge clk);
        check("w_after_aw", slv_w_ready_o[3], 1);
        @(posedge clk); #1;
        slv_w_valid_i[3] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // concurrent read for requester 1 and write for requester 0
        @(negedge clk);
        check("r_spurious_stall", {mst_r_ready_o, slv_r_valid_o}, 0);
        @(posedge clk); #1;
        mst_ar_ready_i = 1'b1;
        exp_ar.push_back(32'hB000_0100);
        exp_r.push_back({2'd1, 2'b00, 32'h1234_5678});
        expect_write(0, 5);
        start = cyc;
        fork
            do_write(0, 5);
            do_read(1, 32'hB000_0100);
        join
        check("conc_no_stall", (cyc - start) <= 3, 1);
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        check("aw_drained", exp_aw.size(), 0);
        check("w_drained", exp_w.size(), 0);
        check("b_drained", exp_b.size(), 0);
        check("ar_drained", exp_ar.size(), 0);
        check("r_drained", exp_r.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
